// File: rtl/midi_voice_pkg.sv
// midi_voice_pkg
//   Shared constants for the MIDI voice allocator: FSM state encoding,
//   MIDI status nibbles, controller numbers and the omni-channel marker.
//   No ports.
package midi_voice_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_APPLY,
      ST_GAP,
      ST_ACK
   } state_t;

   localparam logic [3:0] CMD_NOTE_OFF     = 4'h8;
   localparam logic [3:0] CMD_NOTE_ON      = 4'h9;
   localparam logic [3:0] CMD_CC           = 4'hB;

   localparam logic [6:0] CC_SUSTAIN       = 7'h40;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

   localparam int         OMNI_CHANNEL     = 16;

endpackage

// File: rtl/midi_voice_age_tracker.sv
// midi_voice_age_tracker
//   Per-voice saturating age counters. A touch resets the touched voice to
//   age 0 and advances every other voice by one, saturating at
//   NUM_VOICES-1, so the largest age marks the least recently started voice.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   touch         strobe: a note-on has been assigned to touch_index
//   touch_index   voice that received the note-on
//   age           packed age vector, one AGE_W field per voice
module midi_voice_age_tracker #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = $clog2(NUM_VOICES)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                touch,
   input  logic [AGE_W-1:0]                    touch_index,
   output logic [NUM_VOICES-1:0][AGE_W-1:0]    age
);

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_age
      always_ff @(posedge clk) begin
         if (rst) begin
            age[v] <= '0;
         end else if (touch) begin
            if (touch_index == AGE_W'(v))
               age[v] <= '0;
            else if (age[v] != AGE_MAX)
               age[v] <= age[v] + AGE_W'(1);
         end
      end
   end

endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Polyphonic voice allocator. Consumes framed MIDI events over a
//   valid/ack handshake and drives per-voice gate/note/velocity registers.
//   Note-on: same-note retrigger, else lowest idle voice, else steal the
//   oldest voice with a forced gate-low gap of STEAL_GAP_CYCLES.
//   Note-off (0x8n, or 0x9n velocity 0) releases matching gated voices;
//   CC 0x7B releases all voices.
//   Optional build macro MIDI_VOICE_ALLOC_SUSTAIN_EN adds sustain pedal
//   (CC 0x40) handling with a per-voice sustained bit.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   midi_event_valid    framed event available
//   midi_command        status byte
//   midi_parameter_1    note / controller number
//   midi_parameter_2    velocity / controller value
//   midi_event_ack      one-cycle pulse: event consumed
//   voice_gate          per-voice gate
//   voice_note          note of voice v at [7v+6:7v]
//   voice_velocity      velocity of voice v at [7v+6:7v]
//   busy                high whenever the FSM is not idle
module midi_voice_allocator
   import midi_voice_pkg::*;
#(
   parameter int NUM_VOICES       = 4,
   parameter int MIDI_CHANNEL     = 16,
   parameter int STEAL_GAP_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      midi_event_valid,
   input  logic [7:0]                midi_command,
   input  logic [6:0]                midi_parameter_1,
   input  logic [6:0]                midi_parameter_2,
   output logic                      midi_event_ack,
   output logic [NUM_VOICES-1:0]     voice_gate,
   output logic [7*NUM_VOICES-1:0]   voice_note,
   output logic [7*NUM_VOICES-1:0]   voice_velocity,
   output logic                      busy
);

   localparam int AGE_W = $clog2(NUM_VOICES);
   localparam int GAP_W = (STEAL_GAP_CYCLES > 1) ? $clog2(STEAL_GAP_CYCLES) : 1;
   localparam logic [AGE_W-1:0] LAST_VOICE = AGE_W'(NUM_VOICES - 1);
   localparam logic [GAP_W-1:0] LAST_GAP   = GAP_W'(STEAL_GAP_CYCLES - 1);

   state_t                            state, state_next;
   logic [3:0]                        cmd_hi;
   logic [6:0]                        param1, param2;
   logic [AGE_W-1:0]                  scan_idx, retrig_idx, idle_idx;
   logic [AGE_W-1:0]                  oldest_idx, oldest_age, target;
   logic                              retrig_found, idle_found;
   logic [GAP_W-1:0]                  gap_cnt;
   logic [NUM_VOICES-1:0]             gate;
   logic [NUM_VOICES-1:0][6:0]        note, vel;
   logic [NUM_VOICES-1:0][AGE_W-1:0]  age;
   logic                              accept, touch, chan_ok, in_note_on;
   logic                              is_note_on, is_note_off, is_cc;
`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
   logic [NUM_VOICES-1:0]             sustained;
   logic                              pedal;
`endif

   assign midi_event_ack = (state == ST_ACK);
   assign busy           = (state != ST_IDLE);
   assign accept         = (state == ST_IDLE) && midi_event_valid && !midi_event_ack;

   assign chan_ok    = (MIDI_CHANNEL == OMNI_CHANNEL) ||
                       (midi_command[3:0] == 4'(MIDI_CHANNEL));
   assign in_note_on = (midi_command[7:4] == CMD_NOTE_ON) && (midi_parameter_2 != 7'd0);

   // Decode of the latched event, used in APPLY.
   assign is_note_on  = (cmd_hi == CMD_NOTE_ON) && (param2 != 7'd0);
   assign is_note_off = (cmd_hi == CMD_NOTE_OFF) ||
                        ((cmd_hi == CMD_NOTE_ON) && (param2 == 7'd0));
   assign is_cc       = (cmd_hi == CMD_CC);

   // Retrigger beats idle beats steal.
   assign target = retrig_found ? retrig_idx : (idle_found ? idle_idx : oldest_idx);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      touch      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!chan_ok)        state_next = ST_ACK;
               else if (in_note_on) state_next = ST_SCAN;
               else                 state_next = ST_APPLY;
            end
         end
         ST_SCAN:  if (scan_idx == LAST_VOICE) state_next = ST_APPLY;
         ST_APPLY: begin
            touch = is_note_on;
            if (is_note_on && !retrig_found && !idle_found) state_next = ST_GAP;
            else                                             state_next = ST_ACK;
         end
         ST_GAP:   if (gap_cnt == LAST_GAP) state_next = ST_ACK;
         ST_ACK:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   midi_voice_age_tracker #(
      .NUM_VOICES (NUM_VOICES),
      .AGE_W      (AGE_W)
   ) u_age (
      .clk         (clk),
      .rst         (rst),
      .touch       (touch),
      .touch_index (target),
      .age         (age)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_hi       <= '0;
         param1       <= '0;
         param2       <= '0;
         scan_idx     <= '0;
         retrig_idx   <= '0;
         idle_idx     <= '0;
         oldest_idx   <= '0;
         oldest_age   <= '0;
         retrig_found <= 1'b0;
         idle_found   <= 1'b0;
         gap_cnt      <= '0;
         gate         <= '0;
         note         <= '0;
         vel          <= '0;
`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
         sustained    <= '0;
         pedal        <= 1'b0;
`endif
      end else begin
         if (accept) begin
            cmd_hi       <= midi_command[7:4];
            param1       <= midi_parameter_1;
            param2       <= midi_parameter_2;
            scan_idx     <= '0;
            retrig_found <= 1'b0;
            idle_found   <= 1'b0;
            oldest_idx   <= '0;
            oldest_age   <= '0;
            gap_cnt      <= '0;
         end

         if (state == ST_SCAN) begin
            if (!retrig_found && gate[scan_idx] && (note[scan_idx] == param1)) begin
               retrig_found <= 1'b1;
               retrig_idx   <= scan_idx;
            end
            if (!idle_found && !gate[scan_idx]) begin
               idle_found <= 1'b1;
               idle_idx   <= scan_idx;
            end
            // Strictly greater keeps the lowest index on ties.
            if (age[scan_idx] > oldest_age) begin
               oldest_age <= age[scan_idx];
               oldest_idx <= scan_idx;
            end
            scan_idx <= scan_idx + AGE_W'(1);
         end

         if (state == ST_APPLY) begin
            if (is_note_on) begin
               vel[target] <= param2;
               if (!retrig_found) note[target] <= param1;
               // A stolen voice drops its gate here and regates after the gap.
               gate[target] <= retrig_found | idle_found;
`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
               sustained[target] <= 1'b0;
`endif
            end else if (is_note_off) begin
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (gate[v] && (note[v] == param1)) begin
`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
                     if (pedal) sustained[v] <= 1'b1;
                     else       gate[v]      <= 1'b0;
`else
                     gate[v] <= 1'b0;
`endif
                  end
               end
            end else if (is_cc) begin
               if (param1 == CC_ALL_NOTES_OFF) begin
                  gate <= '0;
`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
                  sustained <= '0;
`endif
               end
`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
               else if (param1 == CC_SUSTAIN) begin
                  pedal <= param2[6];
                  if (!param2[6]) begin
                     gate      <= gate & ~sustained;
                     sustained <= '0;
                  end
               end
`endif
            end
         end

         if (state == ST_GAP) begin
            if (gap_cnt == LAST_GAP) gate[oldest_idx] <= 1'b1;
            else                     gap_cnt <= gap_cnt + GAP_W'(1);
         end
      end
   end

   assign voice_gate     = gate;
   assign voice_note     = note;
   assign voice_velocity = vel;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator
//   Directed bench for midi_voice_allocator with NUM_VOICES=4: an omni
//   instance driven from a vector table, plus a channel-2 instance and
//   hand-written reset / sustain sequences.
module tb_midi_voice_allocator;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0, valid_ch = 1'b0;
   logic [7:0]    cmd = 8'h00;
   logic [6:0]    p1 = 7'd0, p2 = 7'd0;
   logic          ack, busy, ack_ch, busy_ch;
   logic [N-1:0]  gate, gate_ch;
   logic [7*N-1:0] note, vel, note_ch, vel_ch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(16), .STEAL_GAP_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .midi_event_valid(valid), .midi_command(cmd),
      .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack),
      .voice_gate(gate), .voice_note(note), .voice_velocity(vel), .busy(busy));

   midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(2), .STEAL_GAP_CYCLES(64)) dut_ch (
      .clk(clk), .rst(rst), .midi_event_valid(valid_ch), .midi_command(cmd),
      .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack_ch),
      .voice_gate(gate_ch), .voice_note(note_ch), .voice_velocity(vel_ch), .busy(busy_ch));

   typedef struct {
      logic [7:0]  cmd;
      logic [6:0]  p1, p2;
      int          lat;    // cycles from acceptance to ack
      logic [3:0]  gate;
      logic [27:0] note;   // {v3,v2,v1,v0}
      logic [27:0] vel;
      int          low;    // cycles voice0 gate is low while in flight, -1 = skip
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Presents one event and waits (bounded) for its ack; returns latency in
   // cycles after acceptance, busy-high count and voice0 gate-low count.
   task automatic send(input int which, input logic [7:0] c, input logic [6:0] a,
                       input logic [6:0] b, output int lat, output int bcnt, output int lcnt);
      @(negedge clk);
      cmd = c; p1 = a; p2 = b;
      if (which == 0) valid = 1'b1; else valid_ch = 1'b1;
      lat = -1; bcnt = 0; lcnt = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) begin valid = 1'b0; valid_ch = 1'b0; end
         if (which == 0 ? busy : busy_ch) bcnt++;
         if (which == 0 && !gate[0]) lcnt++;
         if (which == 0 ? ack : ack_ch) begin lat = k; break; end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt, lcnt, acks;

      tv[0]  = '{8'h90, 7'd60, 7'd100, 6,  4'b0001, {7'd0, 7'd0, 7'd0, 7'd60},   {7'd0, 7'd0, 7'd0, 7'd100},   -1};
      tv[1]  = '{8'h90, 7'd62, 7'd80,  6,  4'b0011, {7'd0, 7'd0, 7'd62, 7'd60},  {7'd0, 7'd0, 7'd80, 7'd100},  -1};
      tv[2]  = '{8'h90, 7'd64, 7'd70,  6,  4'b0111, {7'd0, 7'd64, 7'd62, 7'd60}, {7'd0, 7'd70, 7'd80, 7'd100}, -1};
      tv[3]  = '{8'h90, 7'd65, 7'd60,  6,  4'b1111, {7'd65, 7'd64, 7'd62, 7'd60}, {7'd60, 7'd70, 7'd80, 7'd100}, -1};
      // Steal oldest (voice0): gate low for 64 cycles, regated with ack.
      tv[4]  = '{8'h90, 7'd67, 7'd90,  70, 4'b1111, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd80, 7'd90},  64};
      tv[5]  = '{8'h80, 7'd62, 7'd0,   2,  4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd80, 7'd90},  -1};
      tv[6]  = '{8'h90, 7'd62, 7'd50,  6,  4'b1111, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd50, 7'd90},  -1};
      tv[7]  = '{8'h90, 7'd62, 7'd0,   2,  4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd50, 7'd90},  -1};
      tv[8]  = '{8'h80, 7'd70, 7'd0,   2,  4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd50, 7'd90},  -1};
      // Retrigger wins over the idle voice1.
      tv[9]  = '{8'h90, 7'd67, 7'd33,  6,  4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd50, 7'd33},  -1};
      tv[10] = '{8'hB0, 7'h7B, 7'd0,   2,  4'b0000, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd50, 7'd33},  -1};
      tv[11] = '{8'hC0, 7'd5,  7'd0,   2,  4'b0000, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd60, 7'd70, 7'd50, 7'd33},  -1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_gate", 32'(gate), 0);
      chk("rst_note", 32'(note), 0);
      chk("rst_vel",  32'(vel),  0);
      chk("rst_ack",  32'(ack),  0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         send(0, tv[i].cmd, tv[i].p1, tv[i].p2, lat, bcnt, lcnt);
         chk($sformatf("v%0d_lat", i),  32'(lat),    32'(tv[i].lat));
         chk($sformatf("v%0d_busy", i), 32'(bcnt),   32'(tv[i].lat));
         chk($sformatf("v%0d_gate", i), 32'(gate),   32'(tv[i].gate));
         chk($sformatf("v%0d_note", i), 32'(note),   32'(tv[i].note));
         chk($sformatf("v%0d_vel", i),  32'(vel),    32'(tv[i].vel));
         if (tv[i].low >= 0) chk($sformatf("v%0d_gap", i), 32'(lcnt), 32'(tv[i].low));
      end
      @(negedge clk);
      chk("busy_after_ack", 32'(busy), 0);
      chk("ack_one_cycle",  32'(ack),  0);

      // Reset in the middle of a SCAN abandons the event.
      @(negedge clk);
      cmd = 8'h90; p1 = 7'd70; p2 = 7'd10; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("scan_busy", 32'(busy), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_gate", 32'(gate), 0);
      chk("midrst_note", 32'(note), 0);
      chk("midrst_vel",  32'(vel),  0);
      chk("midrst_ack",  32'(ack),  0);
      chk("midrst_busy", 32'(busy), 0);
      rst = 1'b0;
      acks = 0;
      repeat (10) begin
         @(negedge clk);
         if (ack) acks++;
      end
      chk("midrst_no_ack", 32'(acks), 0);

      // Channel filter on the channel-2 instance.
      send(1, 8'h91, 7'd60, 7'd100, lat, bcnt, lcnt);
      chk("ch1_lat",  32'(lat),     1);
      chk("ch1_gate", 32'(gate_ch), 0);
      send(1, 8'h92, 7'd60, 7'd100, lat, bcnt, lcnt);
      chk("ch2_lat",  32'(lat),     6);
      chk("ch2_gate", 32'(gate_ch), 1);
      chk("ch2_note", 32'(note_ch), 60);
      chk("ch2_vel",  32'(vel_ch),  100);

`ifdef MIDI_VOICE_ALLOC_SUSTAIN_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(0, 8'hB0, 7'h40, 7'd127, lat, bcnt, lcnt);
      chk("sus_down_lat", 32'(lat), 2);
      send(0, 8'h90, 7'd60, 7'd100, lat, bcnt, lcnt);
      chk("sus_on_gate", 32'(gate), 1);
      send(0, 8'h80, 7'd60, 7'd0, lat, bcnt, lcnt);
      chk("sus_off_gate", 32'(gate), 1);
      send(0, 8'hB0, 7'h40, 7'd0, lat, bcnt, lcnt);
      chk("sus_up_lat",  32'(lat),  2);
      chk("sus_up_gate", 32'(gate), 0);
`else
      // Without sustain support CC 64 is ignored.
      send(0, 8'hB0, 7'h40, 7'd127, lat, bcnt, lcnt);
      send(0, 8'h90, 7'd60, 7'd100, lat, bcnt, lcnt);
      send(0, 8'h80, 7'd60, 7'd0, lat, bcnt, lcnt);
      chk("nosus_off_gate", 32'(gate), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
